// File: rtl/bus_xfer_pkg.sv
// bus_xfer_pkg: shared definitions for the bus transfer sequencer.
//   - Bus source / destination codes as seen by the datapath bus mux.
//   - Default bus widths (NSRC, NDST) and request word layout.
//   - FSM state encoding for bus_xfer_ctrl.
// Optional feature macro used by the slice: BUS_XFER_STATS_EN.
package bus_xfer_pkg;

  localparam int NSRC   = 24;
  localparam int NDST   = 24;
  localparam int CODE_W = 5;
  // A queued request is {source code, destination code}.
  localparam int REQ_W  = 2 * CODE_W;

  localparam logic [CODE_W-1:0]
    SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3,
    SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7,
    SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11,
    SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15,
    SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHIGH = 5'd18, SRC_ZLOW = 5'd19,
    SRC_PC  = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22, SRC_C = 5'd23;

  localparam logic [CODE_W-1:0]
    DST_R0  = 5'd0,  DST_R1  = 5'd1,  DST_R2  = 5'd2,  DST_R3  = 5'd3,
    DST_R4  = 5'd4,  DST_R5  = 5'd5,  DST_R6  = 5'd6,  DST_R7  = 5'd7,
    DST_R8  = 5'd8,  DST_R9  = 5'd9,  DST_R10 = 5'd10, DST_R11 = 5'd11,
    DST_R12 = 5'd12, DST_R13 = 5'd13, DST_R14 = 5'd14, DST_R15 = 5'd15,
    DST_HI  = 5'd16, DST_LO  = 5'd17, DST_PC  = 5'd18, DST_MDR = 5'd19,
    DST_MAR = 5'd20, DST_IR  = 5'd21, DST_Y   = 5'd22, DST_OUTPORT = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// bus_xfer_ctrl_if: request handshake plus bus enable outputs of bus_xfer_ctrl.
//   master modport: control unit side (offers requests, observes enables/status).
//   slave  modport: bus_xfer_ctrl side.
//   Signals: req_valid/req_ready/req_src/req_dst, src_out[NSRC], dst_in[NDST],
//            busy, xfer_done, xfer_err, level[clog2(DEPTH)+1].
//   With BUS_XFER_STATS_EN defined: xfer_count[15:0], err_count[7:0].
interface bus_xfer_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int NSRC  = bus_xfer_pkg::NSRC,
  parameter int NDST  = bus_xfer_pkg::NDST
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_src;
  logic [4:0]       req_dst;
  logic [NSRC-1:0]  src_out;
  logic [NDST-1:0]  dst_in;
  logic             busy;
  logic             xfer_done;
  logic             xfer_err;
  logic [LVL_W-1:0] level;
`ifdef BUS_XFER_STATS_EN
  logic [15:0]      xfer_count;
  logic [7:0]       err_count;
`endif

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, src_out, dst_in, busy, xfer_done, xfer_err, level
`ifdef BUS_XFER_STATS_EN
    , input xfer_count, err_count
`endif
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, src_out, dst_in, busy, xfer_done, xfer_err, level
`ifdef BUS_XFER_STATS_EN
    , output xfer_count, err_count
`endif
  );

endinterface

// File: rtl/bus_xfer_fifo.sv
// bus_xfer_fifo: synchronous DEPTH x WIDTH request FIFO with explicit occupancy counter.
//   clk_i, rst_i   : clock, synchronous active-high reset (pointers/level only)
//   push_i, data_i : write request (ignored when full)
//   pop_i, data_o  : read request (ignored when empty); data_o shows the head
//   full_o, empty_o, level_o : status, derived from registered occupancy
module bus_xfer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = bus_xfer_pkg::REQ_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  import bus_xfer_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: bus-side transfer sequencer driving the datapath bus mux.
//   clock : rising-edge clock
//   clear : synchronous active-high reset (also aborts an in-flight transfer)
//   bus   : bus_xfer_ctrl_if.slave -- request handshake in, one-hot src_out /
//           dst_in enables, busy, xfer_done / xfer_err pulses, FIFO level out.
// Each queued {src, dst} request becomes one DRIVE cycle (source enable only,
// bus settles) followed by one LATCH cycle (source held, destination enable and
// xfer_done). Requests with codes outside the bus width are dropped with xfer_err.
// Optional: BUS_XFER_STATS_EN adds xfer_count (wrapping) and err_count (saturating).
module bus_xfer_ctrl #(
  parameter int DEPTH = 4,
  parameter int NSRC  = bus_xfer_pkg::NSRC,
  parameter int NDST  = bus_xfer_pkg::NDST
) (
  input  logic           clock,
  input  logic           clear,
  bus_xfer_ctrl_if.slave bus
);
  import bus_xfer_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [NSRC-1:0]   src_out_q, src_out_d;
  logic [NDST-1:0]   dst_in_q, dst_in_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CODE_W-1:0] dst_code_q, dst_code_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0]  fifo_head;
  logic [LVL_W-1:0]  fifo_level;
  logic [CODE_W-1:0] head_src, head_dst;
  logic              head_ok;

  function automatic logic [NSRC-1:0] src_onehot(input logic [CODE_W-1:0] code);
    logic [NSRC-1:0] v;
    v = '0;
    for (int i = 0; i < NSRC; i++) v[i] = (int'(code) == i);
    return v;
  endfunction

  function automatic logic [NDST-1:0] dst_onehot(input logic [CODE_W-1:0] code);
    logic [NDST-1:0] v;
    v = '0;
    for (int i = 0; i < NDST; i++) v[i] = (int'(code) == i);
    return v;
  endfunction

  assign fifo_push = bus.req_valid && !fifo_full;

  bus_xfer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (clear),
    .push_i  (fifo_push),
    .data_i  ({bus.req_src, bus.req_dst}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign head_src = fifo_head[REQ_W-1:CODE_W];
  assign head_dst = fifo_head[CODE_W-1:0];
  assign head_ok  = (int'(head_src) < NSRC) && (int'(head_dst) < NDST);

  // Outputs are registered: the next-state logic also computes what the
  // enables must show while in the next state.
  always_comb begin
    state_d    = state_q;
    src_out_d  = '0;
    dst_in_d   = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    dst_code_d = dst_code_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE, LATCH: begin
        // LATCH is the last cycle of a transfer, so the bus is free to start
        // the next one immediately; this gives the 2-cycle cadence.
        state_d = IDLE;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_ok) begin
            state_d    = DRIVE;
            src_out_d  = src_onehot(head_src);
            dst_code_d = head_dst;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        state_d   = LATCH;
        src_out_d = src_out_q;
        dst_in_d  = dst_onehot(dst_code_q);
        done_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      src_out_q <= '0;
      dst_in_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_out_q <= src_out_d;
      dst_in_q  <= dst_in_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    dst_code_q <= dst_code_d;
  end

  assign bus.req_ready = !fifo_full;
  assign bus.src_out   = src_out_q;
  assign bus.dst_in    = dst_in_q;
  assign bus.xfer_done = done_q;
  assign bus.xfer_err  = err_q;
  assign bus.level     = fifo_level;
  assign bus.busy      = !fifo_empty || (state_q != IDLE);

`ifdef BUS_XFER_STATS_EN
  logic [15:0] xfer_count_q;
  logic [7:0]  err_count_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      xfer_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      if (done_q) xfer_count_q <= xfer_count_q + 16'd1;
      if (err_q && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.xfer_count = xfer_count_q;
  assign bus.err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: self-checking bench for bus_xfer_ctrl.
// A transaction-level model (request queue plus "bus cycles remaining" for the
// current transfer) predicts every output each cycle; directed scenarios add
// explicit checks for the documented cases, followed by randomized traffic.
// Honours BUS_XFER_STATS_EN when defined.
module tb_bus_xfer_ctrl;
  import bus_xfer_pkg::*;

  localparam int DEPTH = 4;
  localparam int NS    = 24;
  localparam int ND    = 24;

  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  bus_xfer_ctrl_if #(.DEPTH(DEPTH), .NSRC(NS), .NDST(ND)) bus ();

  bus_xfer_ctrl #(.DEPTH(DEPTH), .NSRC(NS), .NDST(ND)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: queued requests and the transfer currently shown on the bus.
  logic [9:0] mq[$];
  int         m_left = 0;   // 2: settle cycle shown, 1: latch cycle shown, 0: bus idle
  logic [4:0] m_src  = '0;
  logic [4:0] m_dst  = '0;
  bit         m_err  = 1'b0;
  int         m_xc   = 0;
  int         m_ec   = 0;

  // Directed-scenario bookkeeping
  int cyc_no    = 0;
  int last_done = -1;
  int n_done    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit v, input logic [4:0] s, input logic [4:0] d, input bit c);
    bit         room;
    bit         nerr;
    logic [9:0] head;
    logic [4:0] hs, hd;
    if (c) begin
      mq.delete();
      m_left = 0;
      m_err  = 1'b0;
      m_xc   = 0;
      m_ec   = 0;
      return;
    end
    room = (mq.size() < DEPTH);
    nerr = 1'b0;
    if (m_left == 1) m_xc = (m_xc + 1) % 65536;
    if (m_err && m_ec < 255) m_ec++;
    if (m_left == 2) begin
      m_left = 1;
    end else if (mq.size() != 0) begin
      head = mq.pop_front();
      hs = head[9:5];
      hd = head[4:0];
      if (int'(hs) < NS && int'(hd) < ND) begin
        m_src  = hs;
        m_dst  = hd;
        m_left = 2;
      end else begin
        nerr   = 1'b1;
        m_left = 0;
      end
    end else begin
      m_left = 0;
    end
    if (v && room) mq.push_back({s, d});
    m_err = nerr;
  endtask

  task automatic compare_all();
    logic [63:0] es, ed;
    es = (m_left > 0)  ? (64'd1 << m_src) : 64'd0;
    ed = (m_left == 1) ? (64'd1 << m_dst) : 64'd0;
    check("src_out",   64'(bus.src_out),   es);
    check("dst_in",    64'(bus.dst_in),    ed);
    check("xfer_done", 64'(bus.xfer_done), 64'(m_left == 1));
    check("xfer_err",  64'(bus.xfer_err),  64'(m_err));
    check("level",     64'(bus.level),     64'(mq.size()));
    check("req_ready", 64'(bus.req_ready), 64'(mq.size() < DEPTH));
    check("busy",      64'(bus.busy),      64'(mq.size() != 0 || m_left != 0));
`ifdef BUS_XFER_STATS_EN
    check("xfer_count", 64'(bus.xfer_count), 64'(m_xc));
    check("err_count",  64'(bus.err_count),  64'(m_ec));
`endif
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later.
  task automatic step(input bit v, input logic [4:0] s, input logic [4:0] d, input bit c);
    bus.req_valid = v;
    bus.req_src   = s;
    bus.req_dst   = d;
    clear         = c;
    @(posedge clock);
    model_edge(v, s, d, c);
    #1;
    compare_all();
    cyc_no++;
    @(negedge clock);
  endtask

  task automatic note_done();
    if (bus.xfer_done) begin
      if (last_done >= 0) check("done_gap", 64'(cyc_no - last_done), 64'd2);
      last_done = cyc_no;
      n_done++;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic t_back_to_back();
    int  sent;
    bit  acc;
    bit  saw_full;
    sent      = 0;
    saw_full  = 1'b0;
    last_done = -1;
    n_done    = 0;
    for (int k = 0; k < 100 && sent < 8; k++) begin
      acc = bus.req_ready;
      step(1'b1, 5'(sent), 5'(sent + 8), 1'b0);
      if (acc) sent++;
      if (!bus.req_ready) saw_full = 1'b1;
      note_done();
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 5'd0, 5'd0, 1'b0);
      note_done();
    end
    check("b2b_sent", 64'(sent), 64'd8);
    check("b2b_done_pulses", 64'(n_done), 64'd8);
    check("b2b_full_seen", 64'(saw_full), 64'd1);
  endtask

  task automatic t_invalid();
    int n_err;
    bit saw_src2, saw_dst4, enable_on_err;
    n_err = 0;
    saw_src2 = 1'b0;
    saw_dst4 = 1'b0;
    enable_on_err = 1'b0;
    step(1'b1, 5'd25, 5'd2, 1'b0);
    step(1'b1, 5'd1,  5'd2, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (bus.xfer_err) begin
        n_err++;
        if (bus.src_out != '0 || bus.dst_in != '0) enable_on_err = 1'b1;
      end
      if (bus.src_out == 24'h000002) saw_src2 = 1'b1;
      if (bus.dst_in  == 24'h000004) saw_dst4 = 1'b1;
      step(1'b0, 5'd0, 5'd0, 1'b0);
    end
    check("inv_err_pulses", 64'(n_err), 64'd1);
    check("inv_no_enables", 64'(enable_on_err), 64'd0);
    check("inv_src2_seen", 64'(saw_src2), 64'd1);
    check("inv_dst4_seen", 64'(saw_dst4), 64'd1);
  endtask

  logic [4:0] rs, rd;
  bit         rv, rc;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_src   = '0;
    bus.req_dst   = '0;
    clear         = 1'b1;
    @(negedge clock);

    // Reset state
    do_reset();
    check("rst_src_out", 64'(bus.src_out), 64'd0);
    check("rst_dst_in", 64'(bus.dst_in), 64'd0);
    check("rst_level", 64'(bus.level), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);

    // MDR -> R3 into an idle block
    step(1'b1, SRC_MDR, DST_R3, 1'b0);
    check("mdr_push_src", 64'(bus.src_out), 64'd0);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    check("mdr_drive_src", 64'(bus.src_out), 64'h200000);
    check("mdr_drive_dst", 64'(bus.dst_in), 64'd0);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    check("mdr_latch_src", 64'(bus.src_out), 64'h200000);
    check("mdr_latch_dst", 64'(bus.dst_in), 64'h000008);
    check("mdr_latch_done", 64'(bus.xfer_done), 64'd1);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    check("mdr_after_src", 64'(bus.src_out), 64'd0);
    check("mdr_after_busy", 64'(bus.busy), 64'd0);

    t_back_to_back();
    t_invalid();

    // Same source and destination register
    step(1'b1, SRC_R5, DST_R5, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 5'd0, 5'd0, 1'b0);

    // Clear during DRIVE of HI -> MAR
    step(1'b1, SRC_HI, DST_MAR, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    check("clr_drive_src", 64'(bus.src_out), 64'h010000);
    step(1'b0, 5'd0, 5'd0, 1'b1);
    check("clr_src_out", 64'(bus.src_out), 64'd0);
    check("clr_dst_in", 64'(bus.dst_in), 64'd0);
    check("clr_level", 64'(bus.level), 64'd0);
    check("clr_busy", 64'(bus.busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 5'd0, 5'd0, 1'b0);
      check("clr_no_latch", 64'(bus.dst_in), 64'd0);
    end

`ifdef BUS_XFER_STATS_EN
    do_reset();
    step(1'b1, SRC_PC, DST_MAR, 1'b0);
    step(1'b1, SRC_R2, DST_Y, 1'b0);
    step(1'b1, 5'd30, DST_IR, 1'b0);
    step(1'b1, SRC_C, DST_OUTPORT, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 5'd0, 5'd0, 1'b0);
    check("stats_xfer_count", 64'(bus.xfer_count), 64'd3);
    check("stats_err_count", 64'(bus.err_count), 64'd1);
`endif

    // Randomized traffic with occasional invalid codes and clears
    for (int k = 0; k < 1500; k++) begin
      rv = ($urandom_range(0, 9) < 7);
      rc = ($urandom_range(0, 149) == 0);
      rs = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      rd = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      step(rv, rs, rd, rc);
    end
    for (int k = 0; k < 12; k++) step(1'b0, 5'd0, 5'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
